// File: rtl/conv_host_ctrl.sv
// Host-side partner of the convolution engine: streams the x buffer out over a
// valid/ready master port, raises conv_start, and captures y results into a readback buffer.
module conv_host_ctrl #(
  parameter int X_MEM_SIZE = 8,
  parameter int F_MEM_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int Y_WIDTH    = 19,
  parameter int NUM_Y      = X_MEM_SIZE - F_MEM_SIZE + 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ld_we,
  input  logic [$clog2(X_MEM_SIZE)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  input  logic                          run,
  input  logic                          y_stall,
  output logic [DATA_WIDTH-1:0]         m_data_x,
  output logic                          m_valid_x,
  input  logic                          m_ready_x,
  output logic                          conv_start,
  input  logic [Y_WIDTH-1:0]            s_data_y,
  input  logic                          s_valid_y,
  output logic                          s_ready_y,
  input  logic [$clog2(NUM_Y)-1:0]      rd_addr,
  output logic [Y_WIDTH-1:0]            rd_data,
  output logic                          busy,
  output logic                          done,
  output logic                          y_overflow
);

  localparam int XAW = $clog2(X_MEM_SIZE);
  localparam int YAW = $clog2(NUM_Y);
  localparam int XCW = $clog2(X_MEM_SIZE + 1);
  localparam int YCW = $clog2(NUM_Y + 1);

  localparam logic [XCW-1:0] X_PRIME_LAST = XCW'(F_MEM_SIZE - 1);
  localparam logic [XCW-1:0] X_LAST       = XCW'(X_MEM_SIZE - 1);
  localparam logic [YCW-1:0] Y_FULL       = YCW'(NUM_Y);
  localparam logic [YAW:0]   RD_LIMIT     = (YAW + 1)'(NUM_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [XCW-1:0]       x_idx_q;
  logic [YCW-1:0]       y_idx_q;
  logic                 m_valid_x_q;
  logic                 conv_start_q;
  logic                 done_q;
  logic                 y_ovf_q;

  logic [DATA_WIDTH-1:0] xbuf [X_MEM_SIZE];
  logic [Y_WIDTH-1:0]    ybuf [NUM_Y];

  logic x_fire;
  logic y_fire;
  logic y_store;
  logic ready_state;

  assign ready_state = (state_q == S_STREAM) || (state_q == S_DRAIN) || (state_q == S_DONE);
  assign s_ready_y   = ready_state & ~y_stall;
  assign x_fire      = m_valid_x_q & m_ready_x;
  assign y_fire      = s_valid_y & s_ready_y;
  assign y_store     = y_fire & (y_idx_q != Y_FULL);

  // x_idx only advances on a transfer and xbuf is frozen while busy, so the
  // presented sample stays stable through backpressure.
  assign m_data_x   = xbuf[x_idx_q[XAW-1:0]];
  assign m_valid_x  = m_valid_x_q;
  assign conv_start = conv_start_q;
  assign done       = done_q;
  assign y_overflow = y_ovf_q;
  assign busy       = (state_q != S_IDLE);
  assign rd_data    = ({1'b0, rd_addr} < RD_LIMIT) ? ybuf[rd_addr] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      x_idx_q      <= '0;
      y_idx_q      <= '0;
      m_valid_x_q  <= 1'b0;
      conv_start_q <= 1'b0;
      done_q       <= 1'b0;
      y_ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Results past NUM_Y are still handshaken so the engine never deadlocks.
      if (y_fire) begin
        if (y_idx_q == Y_FULL) begin
          y_ovf_q <= 1'b1;
        end else begin
          y_idx_q <= y_idx_q + 1'b1;
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q     <= S_PRIME;
            x_idx_q     <= '0;
            y_idx_q     <= '0;
            y_ovf_q     <= 1'b0;
            m_valid_x_q <= 1'b1;
          end
        end
        S_PRIME: begin
          if (x_fire) begin
            x_idx_q <= x_idx_q + 1'b1;
            if (x_idx_q == X_PRIME_LAST) begin
              conv_start_q <= 1'b1;
              state_q      <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (x_fire) begin
            x_idx_q <= x_idx_q + 1'b1;
            if (x_idx_q == X_LAST) begin
              m_valid_x_q <= 1'b0;
              state_q     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (y_idx_q == Y_FULL) begin
            conv_start_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we && (state_q == S_IDLE)) begin
      xbuf[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (y_store) begin
      ybuf[y_idx_q[YAW-1:0]] <= s_data_y;
    end
  end

endmodule
